step_seq_checker: RTL and testbench

Receive-side checker for the 3-bit step-code stream produced by the team's step sequencer. The sequencer walks its code 0,1,2,…,DONE_CODE and then holds at DONE_CODE. This block consumes that stream over a valid/ready handshake and confirms that the codes arrive in order. It counts accepted steps, flags completion, and latches a sticky error code on any protocol violation. It sits beside the sequencer as its consumer and self-check monitor.

---
 rtl/step_seq_pkg.sv | 22 ++
 rtl/step_seq_watchdog.sv | 38 +++
 rtl/step_seq_checker.sv | 148 ++++++++++++++
 tb/tb_step_seq_checker.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/step_seq_pkg.sv
// Shared types and defaults for the step sequencer and its receive-side checker.
// Holds the checker state encoding, the error codes and the default code geometry.
package step_seq_pkg;

    localparam int DEF_CODE_W    = 3;
    localparam int DEF_DONE_CODE = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERROR = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE         = 2'd0,
        ERR_BAD_START    = 2'd1,
        ERR_OUT_OF_ORDER = 2'd2,
        ERR_TIMEOUT      = 2'd3
    } err_code_e;

endpackage

// File: rtl/step_seq_watchdog.sv
// Idle-cycle counter: counts enabled cycles without a clear; expire is high during the LIMIT-th such cycle.
// Latency: expire is combinational from the registered count; clear in the same cycle suppresses it.
module step_seq_watchdog #(
    parameter int LIMIT = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic en_i,
    input  logic clr_i,
    output logic expire_o
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && cnt_q != W'(LIMIT)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q idle cycles have already elapsed, so this cycle is idle cycle LIMIT.
    assign expire_o = en_i & ~clr_i & (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/step_seq_checker.sv
// Checks that step codes 0..DONE_CODE arrive in order over valid/ready; counts steps, flags done, latches first error.
// Optional idle timeout in TRACK is built only when STEP_SEQ_CHECKER_TIMEOUT_EN is defined.
module step_seq_checker
    import step_seq_pkg::*;
#(
    parameter int CODE_W      = DEF_CODE_W,
    parameter int DONE_CODE   = DEF_DONE_CODE,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              restart,
    input  logic              in_valid,
    input  logic [CODE_W-1:0] in_code,
    output logic              in_ready,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [CNT_W-1:0]  step_count,
    output logic [CODE_W-1:0] last_code
);

    localparam logic [CODE_W-1:0] DONE_C  = CODE_W'(DONE_CODE);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    state_e            state_q, state_d;
    logic [CODE_W-1:0] expected_q, expected_d;
    logic [CODE_W-1:0] last_code_q, last_code_d;
    logic [CNT_W-1:0]  step_count_q, step_count_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    err_code_e         err_code_q, err_code_d;

    logic beat;
    logic wd_expire;

    assign in_ready = (state_q != ST_ERROR) & ~restart;
    assign beat     = in_valid & in_ready;

`ifdef STEP_SEQ_CHECKER_TIMEOUT_EN
    step_seq_watchdog #(
        .LIMIT (TIMEOUT_CYC)
    ) u_watchdog (
        .clock    (clock),
        .reset    (reset),
        .en_i     (state_q == ST_TRACK),
        .clr_i    (beat | restart | (state_q != ST_TRACK)),
        .expire_o (wd_expire)
    );
`else
    logic timeout_unused;
    assign timeout_unused = (TIMEOUT_CYC != 0);
    assign wd_expire      = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        expected_d   = expected_q;
        last_code_d  = last_code_q;
        step_count_d = step_count_q;
        done_d       = done_q;
        err_d        = err_q;
        err_code_d   = err_code_q;

        case (state_q)
            ST_IDLE: begin
                if (beat) begin
                    if (in_code == '0) begin
                        state_d      = ST_TRACK;
                        expected_d   = CODE_W'(1);
                        step_count_d = CNT_W'(1);
                        last_code_d  = '0;
                    end else begin
                        state_d    = ST_ERROR;
                        err_d      = 1'b1;
                        err_code_d = ERR_BAD_START;
                    end
                end
            end
            ST_TRACK: begin
                if (beat) begin
                    if (in_code == expected_q) begin
                        if (step_count_q != CNT_MAX) begin
                            step_count_d = step_count_q + CNT_W'(1);
                        end
                        expected_d  = expected_q + CODE_W'(1);
                        last_code_d = in_code;
                        if (in_code == DONE_C) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end else if (in_code != last_code_q) begin
                        // A repeat of the last code is the producer stalling, not an error.
                        state_d    = ST_ERROR;
                        err_d      = 1'b1;
                        err_code_d = ERR_OUT_OF_ORDER;
                    end
                end else if (wd_expire) begin
                    state_d    = ST_ERROR;
                    err_d      = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                end
            end
            ST_DONE: begin
                if (beat && in_code != DONE_C) begin
                    state_d    = ST_ERROR;
                    err_d      = 1'b1;
                    err_code_d = ERR_OUT_OF_ORDER;
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // restart is a full synchronous clear and overrides any beat in the same cycle.
    always_ff @(posedge clock) begin
        if (reset || restart) begin
            state_q      <= ST_IDLE;
            expected_q   <= '0;
            last_code_q  <= '0;
            step_count_q <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= ERR_NONE;
        end else begin
            state_q      <= state_d;
            expected_q   <= expected_d;
            last_code_q  <= last_code_d;
            step_count_q <= step_count_d;
            done_q       <= done_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
        end
    end

    assign done       = done_q;
    assign err        = err_q;
    assign err_code   = err_code_q;
    assign step_count = step_count_q;
    assign last_code  = last_code_q;

endmodule

// File: tb/tb_step_seq_checker.sv
// Directed bench for step_seq_checker; timeout scenario runs only when STEP_SEQ_CHECKER_TIMEOUT_EN is defined.
module tb_step_seq_checker;

    logic        clock = 1'b0;
    logic        reset;
    logic        restart;
    logic        in_valid;
    logic [2:0]  in_code;
    logic        in_ready;
    logic        done;
    logic        err;
    logic [1:0]  err_code;
    logic [15:0] step_count;
    logic [2:0]  last_code;

    int checks = 0;
    int errors = 0;

    step_seq_checker #(
        .CODE_W      (3),
        .DONE_CODE   (6),
        .CNT_W       (16),
        .TIMEOUT_CYC (8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .restart    (restart),
        .in_valid   (in_valid),
        .in_code    (in_code),
        .in_ready   (in_ready),
        .done       (done),
        .err        (err),
        .err_code   (err_code),
        .step_count (step_count),
        .last_code  (last_code)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic beat(input logic [2:0] c);
        in_valid = 1'b1;
        in_code  = c;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_restart();
        restart  = 1'b1;
        in_valid = 1'b0;
        tick();
        restart  = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        restart  = 1'b0;
        in_valid = 1'b0;
        in_code  = '0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_ready", 32'(in_ready), 1);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_err_code", 32'(err_code), 0);
        chk("rst_step_count", 32'(step_count), 0);
        chk("rst_last_code", 32'(last_code), 0);
        restart = 1'b1;
        #1;
        chk("restart_ready_low", 32'(in_ready), 0);
        restart = 1'b0;
        #1;

        // In-order stream 0..6 then hold at 6
        for (int c = 0; c <= 6; c++) begin
            in_valid = 1'b1;
            in_code  = 3'(c);
            tick();
            chk("inord_count", 32'(step_count), 32'(c + 1));
            chk("inord_last", 32'(last_code), 32'(c));
            chk("inord_ready", 32'(in_ready), 1);
            chk("inord_done", 32'(done), (c == 6) ? 32'd1 : 32'd0);
        end
        beat(3'd6);
        beat(3'd6);
        chk("hold_done", 32'(done), 1);
        chk("hold_count", 32'(step_count), 7);
        chk("hold_last", 32'(last_code), 6);
        chk("hold_err", 32'(err), 0);
        chk("hold_ready", 32'(in_ready), 1);

        // Bad start, then recovery
        pulse_restart();
        chk("rs_count", 32'(step_count), 0);
        chk("rs_done", 32'(done), 0);
        beat(3'd2);
        chk("bad_err", 32'(err), 1);
        chk("bad_code", 32'(err_code), 1);
        chk("bad_ready", 32'(in_ready), 0);
        chk("bad_count", 32'(step_count), 0);
        pulse_restart();
        chk("bad_rs_err", 32'(err), 0);
        for (int c = 0; c <= 6; c++) beat(3'(c));
        chk("rec_done", 32'(done), 1);
        chk("rec_err", 32'(err), 0);
        chk("rec_count", 32'(step_count), 7);

        // Skip 0,1,2,4
        pulse_restart();
        beat(3'd0);
        beat(3'd1);
        beat(3'd2);
        beat(3'd4);
        chk("skip_err", 32'(err), 1);
        chk("skip_code", 32'(err_code), 2);
        chk("skip_count", 32'(step_count), 3);
        chk("skip_last", 32'(last_code), 2);
        chk("skip_ready", 32'(in_ready), 0);
        beat(3'd3);
        chk("skip_post_count", 32'(step_count), 3);
        chk("skip_post_last", 32'(last_code), 2);
        chk("skip_post_code", 32'(err_code), 2);

        // Repeats with a gap
        pulse_restart();
        beat(3'd0);
        beat(3'd1);
        beat(3'd1);
        chk("rep_count", 32'(step_count), 2);
        idle(5);
        beat(3'd2);
        beat(3'd2);
        chk("rep2_count", 32'(step_count), 3);
        beat(3'd3);
        beat(3'd4);
        beat(3'd5);
        beat(3'd6);
        chk("rep_done", 32'(done), 1);
        chk("rep_final_count", 32'(step_count), 7);
        chk("rep_err", 32'(err), 0);

        // Restart colliding with a code-0 beat
        pulse_restart();
        restart  = 1'b1;
        in_valid = 1'b1;
        in_code  = 3'd0;
        #1;
        chk("coll_ready", 32'(in_ready), 0);
        tick();
        restart  = 1'b0;
        in_valid = 1'b0;
        chk("coll_count", 32'(step_count), 0);
        beat(3'd1);
        chk("coll_still_idle", 32'(err_code), 1);

        // Reset mid-stream, resume at 4
        pulse_restart();
        for (int c = 0; c <= 3; c++) beat(3'(c));
        chk("mid_count", 32'(step_count), 4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_count", 32'(step_count), 0);
        chk("mid_rst_last", 32'(last_code), 0);
        beat(3'd4);
        chk("mid_err", 32'(err), 1);
        chk("mid_code", 32'(err_code), 1);

        // Done followed by a non-DONE code
        pulse_restart();
        for (int c = 0; c <= 6; c++) beat(3'(c));
        beat(3'd2);
        chk("post_done_code", 32'(err_code), 2);
        chk("post_done_done", 32'(done), 1);

`ifdef STEP_SEQ_CHECKER_TIMEOUT_EN
        pulse_restart();
        beat(3'd0);
        beat(3'd1);
        idle(7);
        chk("to_pre_err", 32'(err), 0);
        idle(1);
        chk("to_err", 32'(err), 1);
        chk("to_code", 32'(err_code), 3);
        pulse_restart();
        beat(3'd0);
        beat(3'd1);
        idle(7);
        beat(3'd2);
        chk("to_edge_err", 32'(err), 0);
        chk("to_edge_count", 32'(step_count), 3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
